// File: rtl/buffer_seq_pkg.sv
// Shared types and defaults for the majority-counter readout sequencer.
package buffer_seq_pkg;

    localparam int unsigned BEAT_W      = 256;
    localparam int unsigned CORENUM_DEF = 14;
    localparam int unsigned BEATS_DEF   = 4;

    typedef enum logic [2:0] {
        StIdle,
        StAccum,
        StSettle,
        StStream,
        StDone
    } state_e;

endpackage

// File: rtl/buffer_seq_beat_issuer.sv
// Beat counter and valid/ready handshake that walks the counter bank through its readout beats.
module beat_issuer #(
    parameter int unsigned BEATS = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             dst_ready_i,
    output logic             stream_v_o,
    output logic [IDX_W-1:0] stream_idx_o,
    output logic             dst_valid_o,
    output logic             dst_last_o,
    output logic             last_acc_o
);

    localparam logic [IDX_W:0]   BeatsMax = (IDX_W+1)'(BEATS);
    localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(BEATS-1);

    logic [IDX_W:0]   beat_q, beat_d;
    logic [IDX_W-1:0] held_q, held_d;
    logic             dst_valid_q, dst_valid_d;
    logic             issue;

    // Issue must see this cycle's dst_ready so a held beat is never overwritten
    // while still allowing one beat per cycle under continuous acceptance.
    always_comb begin
        issue       = en_i && (!dst_valid_q || dst_ready_i) && (beat_q < BeatsMax);
        beat_d      = beat_q;
        held_d      = held_q;
        dst_valid_d = dst_valid_q;
        if (clr_i) begin
            beat_d      = '0;
            held_d      = '0;
            dst_valid_d = 1'b0;
        end else if (issue) begin
            beat_d      = beat_q + (IDX_W+1)'(1);
            held_d      = beat_q[IDX_W-1:0];
            dst_valid_d = 1'b1;
        end else if (dst_valid_q && dst_ready_i) begin
            dst_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_q      <= '0;
            held_q      <= '0;
            dst_valid_q <= 1'b0;
        end else begin
            beat_q      <= beat_d;
            held_q      <= held_d;
            dst_valid_q <= dst_valid_d;
        end
    end

    assign stream_v_o   = issue;
    assign stream_idx_o = beat_q[IDX_W-1:0];
    assign dst_valid_o  = dst_valid_q;
    assign dst_last_o   = dst_valid_q && (held_q == LastIdx);
    assign last_acc_o   = dst_valid_q && dst_ready_i && (held_q == LastIdx);

endmodule

// File: rtl/buffer_seq.sv
// Store-pulse sequencer and readout controller for the per-dimension majority-counter bank.
module buffer_seq
    import buffer_seq_pkg::*;
#(
    parameter int unsigned CORENUM = CORENUM_DEF,
    parameter int unsigned BEATS   = BEATS_DEF,
    parameter int unsigned IDX_W   = 2,
    parameter int unsigned SETTLE  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CORENUM-1:0] core_valid,
    input  logic               last,
    output logic [CORENUM-1:0] core_ack,
    output logic [CORENUM-1:0] store,
    output logic               store_flag,
    output logic               stream_v,
    output logic [IDX_W-1:0]   stream_i,
    output logic               dst_valid,
    input  logic               dst_ready,
    output logic               dst_last,
    output logic               busy,
    output logic               done
);

    localparam int unsigned     CNT_W      = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE - 1);

    state_e             state_q, state_d;
    logic               first_q, first_d;
    logic [CNT_W-1:0]   settle_q, settle_d;
    logic [CORENUM-1:0] store_q, store_d;
    logic               flag_q, flag_d;
    logic               busy_q, done_q;
    logic               last_acc;

    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        settle_d = settle_q;
        store_d  = '0;
        flag_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StAccum;
                    first_d = 1'b1;
                end
            end
            StAccum: begin
                store_d = core_valid;
                flag_d  = first_q & (|core_valid);
                if (|core_valid) first_d = 1'b0;
                if (last) begin
                    state_d  = StSettle;
                    settle_d = '0;
                end
            end
            // Counting starts in the cycle the final store pulse is visible.
            StSettle: begin
                if (settle_q == SettleLast) begin
                    state_d  = StStream;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + CNT_W'(1);
                end
            end
            StStream: begin
                if (last_acc) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            first_q  <= 1'b0;
            settle_q <= '0;
            store_q  <= '0;
            flag_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            first_q  <= first_d;
            settle_q <= settle_d;
            store_q  <= store_d;
            flag_q   <= flag_d;
            busy_q   <= (state_d != StIdle);
            done_q   <= (state_d == StDone);
        end
    end

    beat_issuer #(
        .BEATS (BEATS),
        .IDX_W (IDX_W)
    ) u_beat_issuer (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (state_q == StIdle),
        .en_i         (state_q == StStream),
        .dst_ready_i  (dst_ready),
        .stream_v_o   (stream_v),
        .stream_idx_o (stream_i),
        .dst_valid_o  (dst_valid),
        .dst_last_o   (dst_last),
        .last_acc_o   (last_acc)
    );

    assign store      = store_q;
    assign core_ack   = store_q;
    assign store_flag = flag_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
